// File: rtl/audio_in_pkg.sv
// audio_in_pkg: shared FSM state type and counter width for the audio input front end.
package audio_in_pkg;
  localparam int BIT_COUNT_WIDTH = 6;
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SYNCED} state_t;
endpackage

// File: rtl/audio_sync_edge_detect.sv
// audio_sync_edge_detect: synchronizes one asynchronous level into i_clk and emits edge pulses.
// Ports: i_clk/i_reset (async, active-high); i_raw asynchronous input;
//        o_level synchronized level; o_rise/o_fall one-cycle registered edge pulses.
module audio_sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev;
  assign o_level = r_sync[SYNC_STAGES-1];
  // Pulses are registered so they leave the block glitch-free; this puts them
  // SYNC_STAGES+1 cycles behind the raw transition.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_prev <= r_sync[SYNC_STAGES-1];
      o_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      o_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
endmodule

// File: rtl/audio_in_clock_sync.sv
// audio_in_clock_sync: codec BCLK/LRCLK/ADCDAT synchronizer, frame aligner and link monitor.
// Ports: i_clk, i_reset (async, active-high), i_enable, i_clear_status;
//        raw codec inputs i_bit_clk_in, i_left_right_clk_in, i_serial_data_in;
//        edge pulses o_*_rising_edge/o_*_falling_edge, aligned data o_serial_audio_in_data,
//        o_done_channel_sync (frame aligned), o_bits_per_channel, o_clock_lost, o_framing_error.
module audio_in_clock_sync
  import audio_in_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_clear_status,
  input  logic                       i_bit_clk_in,
  input  logic                       i_left_right_clk_in,
  input  logic                       i_serial_data_in,
  output logic                       o_bit_clk_rising_edge,
  output logic                       o_bit_clk_falling_edge,
  output logic                       o_left_right_clk_rising_edge,
  output logic                       o_left_right_clk_falling_edge,
  output logic                       o_serial_audio_in_data,
  output logic                       o_done_channel_sync,
  output logic [BIT_COUNT_WIDTH-1:0] o_bits_per_channel,
  output logic                       o_clock_lost,
  output logic                       o_framing_error
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [BIT_COUNT_WIDTH-1:0] CNT_MAX = '1;
  logic w_bclk_level, w_lr_level, w_bclk_rise_q, w_lr_fall_q, w_lr_edge, w_bclk_edge;
  logic [SYNC_STAGES:0] r_data;
  logic [WD_W-1:0] r_wd;
  logic [BIT_COUNT_WIDTH-1:0] r_bit_cnt;
  logic r_lost_d, r_ref_valid;
  state_t r_state;

  audio_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
    .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_bit_clk_in), .o_level(w_bclk_level),
    .o_rise(o_bit_clk_rising_edge), .o_fall(o_bit_clk_falling_edge)
  );
  audio_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk (
    .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_left_right_clk_in), .o_level(w_lr_level),
    .o_rise(o_left_right_clk_rising_edge), .o_fall(o_left_right_clk_falling_edge)
  );

  // A pulse whose synchronized level has already reverted comes from a runt
  // phase; such pulses are not counted or used for alignment.
  assign w_bclk_rise_q = o_bit_clk_rising_edge & w_bclk_level;
  assign w_lr_fall_q   = o_left_right_clk_falling_edge & ~w_lr_level;
  assign w_lr_edge     = o_left_right_clk_rising_edge | o_left_right_clk_falling_edge;
  assign w_bclk_edge   = o_bit_clk_rising_edge | o_bit_clk_falling_edge;
  // One flop beyond the sync chain lines the data up with the registered pulses.
  assign o_serial_audio_in_data = r_data[SYNC_STAGES];
  assign o_clock_lost = (r_wd == WD_MAX);

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_data    <= '0;
      r_wd      <= '0;
      r_bit_cnt <= '0;
      o_bits_per_channel <= '0;
    end else begin
      r_data <= {r_data[SYNC_STAGES-1:0], i_serial_data_in};
      r_wd   <= w_bclk_edge ? '0 : (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;
      if (w_lr_edge) begin
        o_bits_per_channel <= r_bit_cnt;
        r_bit_cnt <= {{(BIT_COUNT_WIDTH-1){1'b0}}, w_bclk_rise_q};
      end else if (w_bclk_rise_q && r_bit_cnt != CNT_MAX)
        r_bit_cnt <= r_bit_cnt + 1'b1;
    end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state             <= IDLE;
      o_done_channel_sync <= 1'b0;
      r_lost_d            <= 1'b0;
      r_ref_valid         <= 1'b0;
      o_framing_error     <= 1'b0;
    end else begin
      r_lost_d <= o_clock_lost;
      if (!i_enable) begin
        r_state             <= IDLE;
        o_done_channel_sync <= 1'b0;
      end else if (o_clock_lost && !r_lost_d && r_state != IDLE) begin
        r_state             <= WAIT_FRAME;
        o_done_channel_sync <= 1'b0;
      end else
        case (r_state)
          IDLE:       if (!o_clock_lost) r_state <= WAIT_FRAME;
          WAIT_FRAME: if (w_lr_fall_q) begin
            r_state             <= SYNCED;
            o_done_channel_sync <= 1'b1;
          end
          default: ;
        endcase
      // The reference count is only trusted once a full half-period has been
      // latched while aligned.
      r_ref_valid <= (r_state == SYNCED) && (r_ref_valid || w_lr_edge);
      if (w_lr_edge && r_state == SYNCED && r_ref_valid && r_bit_cnt != o_bits_per_channel)
        o_framing_error <= 1'b1;
      else if (i_clear_status)
        o_framing_error <= 1'b0;
    end
endmodule
